// File: rtl/commit_trace_checker.sv
// Golden-trace checker for the processor commit port: buffers expected records, matches them against live commits, latches the first error.
// Build option: define TRACE_LOAD_CHECK_EN to make MemRead commits demand and check LOAD records.
module commit_trace_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [1:0]       exp_kind,
    input  logic [2:0]       exp_reg,
    input  logic [15:0]      exp_addr,
    input  logic [15:0]      exp_data,
    input  logic             RegWrite,
    input  logic [2:0]       WriteRegister,
    input  logic [15:0]      WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [15:0]      MemAddress,
    input  logic [15:0]      MemDataIn,
    input  logic [15:0]      MemDataOut,
    input  logic             Halt,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] err_cycle
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);
`ifdef TRACE_LOAD_CHECK_EN
    localparam bit LoadCheckEn = 1'b1;
`else
    localparam bit LoadCheckEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FAIL,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [2:0]  rd;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    state_e           state;
    rec_t             fifo [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic [PW:0]      count;
    logic [PW:0]      countNext;
    logic [CNT_W-1:0] cycleCount;

    logic             push;
    logic             loadDemand;
    logic [1:0]       n;
    logic [1:0]       popN;
    kind_e            demandKind [3];
    logic [2:0]       cmpCode;
    logic [2:0]       errCode;

    assign loadDemand = MemRead & LoadCheckEn;
    assign exp_ready  = (count < FullCount) && (state != ST_DONE);
    assign push       = exp_valid & exp_ready;

    // Active commit items always occupy the leading slots in REG, LOAD, STORE order.
    always_comb begin
        demandKind[0] = RegWrite ? KIND_REG : (loadDemand ? KIND_LOAD : KIND_STORE);
        demandKind[1] = (RegWrite && loadDemand) ? KIND_LOAD : KIND_STORE;
        demandKind[2] = KIND_STORE;
        n = 2'(RegWrite) + 2'(loadDemand) + 2'(MemWrite);
    end

    function automatic logic [2:0] slotCheck(rec_t e, kind_e want);
        logic [2:0] code;
        code = 3'd0;
        if (e.kind == KIND_RSVD)
            code = 3'd7;
        else if (e.kind != want)
            code = 3'd1;
        else if (want == KIND_REG) begin
            if (e.rd != WriteRegister)
                code = 3'd2;
            else if (e.data != WriteData)
                code = 3'd4;
        end else if (e.addr != MemAddress)
            code = 3'd3;
        else if ((want == KIND_LOAD) ? (e.data != MemDataOut) : (e.data != MemDataIn))
            code = 3'd4;
        return code;
    endfunction

    // The lowest-numbered failing slot determines the reported code.
    always_comb begin
        cmpCode = 3'd0;
        for (int k = 0; k < 3; k++) begin
            if (cmpCode == 3'd0 && 2'(k) < n)
                cmpCode = slotCheck(fifo[rdPtr + PW'(k)], demandKind[k]);
        end
    end

    assign errCode   = (count < {{(PW-1){1'b0}}, n}) ? 3'd5 : cmpCode;
    assign popN      = (state == ST_RUN && errCode == 3'd0) ? n : 2'd0;
    assign countNext = count + (PW+1)'(push) - {{(PW-1){1'b0}}, popN};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
            wrPtr <= '0;
        end else if (push) begin
            fifo[wrPtr] <= {exp_kind, exp_reg, exp_addr, exp_data};
            wrPtr       <= wrPtr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            rdPtr      <= '0;
            count      <= '0;
            cycleCount <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= 3'd0;
            inst_count <= '0;
            err_cycle  <= '0;
        end else begin
            count <= countNext;
            rdPtr <= rdPtr + PW'(popN);
            case (state)
                ST_RUN: begin
                    if (cycleCount != '1)
                        cycleCount <= cycleCount + CNT_W'(1);
                    if (Halt | RegWrite | MemWrite)
                        inst_count <= inst_count + CNT_W'(1);
                    if (Halt)
                        done <= 1'b1;
                    if (errCode != 3'd0) begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        err_code  <= errCode;
                        err_cycle <= cycleCount;
                    end else if (Halt && countNext != '0) begin
                        // Records still queued (or arriving now) at halt were never committed.
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        err_code  <= 3'd6;
                        err_cycle <= cycleCount;
                    end else if (Halt) begin
                        state <= ST_DONE;
                        pass  <= 1'b1;
                    end
                end
                ST_FAIL: begin
                    if (Halt)
                        done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
